// File: rtl/ext_int_arbiter.sv
// External interrupt arbiter: per-source gateways, priority select,
// and a claim/complete handshake driving the machine external interrupt.
module ext_int_arbiter #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   irq_i,
  input  logic              cfg_we_i,
  input  logic              cfg_re_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [63:0]       cfg_wdata_i,
  output logic [63:0]       cfg_rdata_o,
  input  logic              claim_i,
  output logic              claim_ready_o,
  output logic              claim_valid_o,
  output logic [4:0]        claim_id_o,
  input  logic              complete_i,
  input  logic [4:0]        complete_id_i,
  output logic              ext_int_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_SETTLE
  } state_t;

  state_t              r_state;
  state_t              w_nstate;
  logic [PRIO_W-1:0]   r_prio [NSRC];
  logic [NSRC-1:0]     r_enable;
  logic [PRIO_W-1:0]   r_thr;
  logic [NSRC-1:0]     r_edge;
  logic [NSRC-1:0]     r_pend;
  logic [NSRC-1:0]     r_insvc;
  logic [NSRC-1:0]     r_irq_q;
  logic [4:0]          r_best_id;
  logic                r_best_valid;
  logic [63:0]         r_rdata;
  logic                r_cvalid;
  logic [4:0]          r_cid;
  logic                r_ready;

  logic [4:0]          w_sel_id;
  logic                w_sel_valid;
  logic [PRIO_W-1:0]   w_sel_p;
  logic                w_accept;
  logic                w_take;
  logic [NSRC-1:0]     w_claim_clr;
  logic [NSRC-1:0]     w_cmp_clr;
  logic [NSRC-1:0]     w_set;
  logic [63:0]         w_rdata;
  logic                w_unused;

  assign w_unused = ^{cfg_wdata_i[63:NSRC], irq_i[0]};

  // Ascending scan with strict '>' keeps the lowest ID on a priority tie
  always_comb begin
    w_sel_id    = '0;
    w_sel_valid = 1'b0;
    w_sel_p     = r_thr;
    for (int i = 1; i < NSRC; i++) begin
      if (r_pend[i] && r_enable[i] && !r_insvc[i]
          && (r_prio[i] > w_sel_p)) begin
        w_sel_p     = r_prio[i];
        w_sel_id    = 5'(i);
        w_sel_valid = 1'b1;
      end
    end
  end

  assign w_accept    = claim_i & r_ready;
  assign w_take      = w_accept & r_best_valid;
  assign w_claim_clr = w_take ? (NSRC'(1) << r_best_id) : '0;

  always_comb begin
    w_cmp_clr = '0;
    w_set     = '0;
    for (int i = 1; i < NSRC; i++) begin
      w_cmp_clr[i] = complete_i && (complete_id_i == 5'(i))
                     && r_insvc[i];
      w_set[i] = r_edge[i] ? (irq_i[i] & ~r_irq_q[i])
                           : (irq_i[i] & ~r_insvc[i] & ~r_pend[i]);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (cfg_addr_i)
      8'h40:   w_rdata = 64'(r_enable);
      8'h41:   w_rdata = 64'(r_thr);
      8'h42:   w_rdata = 64'(r_pend);
      8'h43:   w_rdata = 64'(r_edge);
      8'h44:   w_rdata = 64'(r_insvc);
      default: begin
        for (int i = 1; i < NSRC; i++)
          if (cfg_addr_i == 8'(i)) w_rdata = 64'(r_prio[i]);
      end
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_nstate = S_RESP;
      S_RESP:   w_nstate = S_SETTLE;
      S_SETTLE: w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_enable     <= '0;
      r_thr        <= '0;
      r_edge       <= '0;
      r_pend       <= '0;
      r_insvc      <= '0;
      r_irq_q      <= '0;
      r_best_id    <= '0;
      r_best_valid <= 1'b0;
      r_rdata      <= '0;
      r_cvalid     <= 1'b0;
      r_cid        <= '0;
      r_ready      <= 1'b0;
      for (int i = 0; i < NSRC; i++) r_prio[i] <= '0;
    end else begin
      r_state      <= w_nstate;
      r_ready      <= (w_nstate == S_IDLE);
      r_irq_q      <= irq_i;
      r_best_id    <= w_sel_id;
      r_best_valid <= w_sel_valid;
      r_cvalid     <= w_accept;
      r_cid        <= w_accept ? r_best_id : '0;
      r_pend       <= w_set | (r_pend & ~w_claim_clr);
      r_insvc      <= (r_insvc & ~w_cmp_clr) | w_claim_clr;
      if (cfg_re_i) r_rdata <= w_rdata;
      if (cfg_we_i) begin
        case (cfg_addr_i)
          8'h40:   r_enable <= cfg_wdata_i[NSRC-1:0] & ~NSRC'(1);
          8'h41:   r_thr    <= cfg_wdata_i[PRIO_W-1:0];
          8'h43:   r_edge   <= cfg_wdata_i[NSRC-1:0];
          default: begin
            for (int i = 1; i < NSRC; i++)
              if (cfg_addr_i == 8'(i))
                r_prio[i] <= cfg_wdata_i[PRIO_W-1:0];
          end
        endcase
      end
    end
  end

  assign cfg_rdata_o   = r_rdata;
  assign claim_ready_o = r_ready;
  assign claim_valid_o = r_cvalid;
  assign claim_id_o    = r_cid;
  assign ext_int_o     = r_best_valid;

endmodule

// File: tb/tb_ext_int_arbiter.sv
// Bench for ext_int_arbiter: directed scenarios plus randomized
// rounds checked against a priority-list reference model.
module tb_ext_int_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        claim = 1'b0;
  logic        ready;
  logic        cvalid;
  logic [4:0]  cid;
  logic        cmp = 1'b0;
  logic [4:0]  cmp_id = '0;
  logic        ext;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ext_int_arbiter #(.NSRC(8), .PRIO_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq),
    .cfg_we_i      (we),
    .cfg_re_i      (re),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .cfg_rdata_o   (rdata),
    .claim_i       (claim),
    .claim_ready_o (ready),
    .claim_valid_o (cvalid),
    .claim_id_o    (cid),
    .complete_i    (cmp),
    .complete_id_i (cmp_id),
    .ext_int_o     (ext)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic complete(input logic [4:0] id);
    cmp_id = id; cmp = 1'b1;
    tick();
    cmp = 1'b0;
  endtask

  task automatic do_reset();
    irq = '0; claim = 1'b0; cmp = 1'b0; we = 1'b0; re = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_claim(output logic [4:0] id, output logic v);
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) begin
      total++; bad++;
      $display("FAIL claim_ready_timeout got=0 exp=1");
    end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    id = cid;
    v = cvalid;
    tick(2);
  endtask

  // Highest prio above threshold, lowest ID on ties, via a packed key
  function automatic int model_pick(input int pr[8], input logic [7:0] c,
                                    input int thr);
    int best = 0;
    int key = -1;
    for (int i = 1; i < 8; i++) begin
      if (c[i] && pr[i] > thr && (pr[i] * 32 + (31 - i)) > key) begin
        key = pr[i] * 32 + (31 - i);
        best = i;
      end
    end
    return best;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL rst_ext got=%b exp=0", ext); end
    total++; if (cvalid !== 1'b0) begin bad++; $display("FAIL rst_cvalid got=%b exp=0", cvalid); end
    total++; if (cid !== 5'd0) begin bad++; $display("FAIL rst_cid got=%0d exp=0", cid); end
    total++; if (rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    rst = 1'b1;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", ready); end
  endtask

  task automatic test_single();
    do_reset();
    wr(8'd3, 64'd2); wr(8'h40, 64'h08); wr(8'h41, 64'd0);
    irq[3] = 1'b1;
    tick();
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL single_e0 got=%b exp=0", ext); end
    tick();
    total++; if (ext !== 1'b1) begin bad++; $display("FAIL single_e1 got=%b exp=1", ext); end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    total++; if (cvalid !== 1'b1) begin bad++; $display("FAIL single_cvalid got=%b exp=1", cvalid); end
    total++; if (cid !== 5'd3) begin bad++; $display("FAIL single_cid got=%0d exp=3", cid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_ready_resp got=%b exp=0", ready); end
    tick();
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", ext); end
    total++; if (cvalid !== 1'b0) begin bad++; $display("FAIL single_cvalid_end got=%b exp=0", cvalid); end
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready_back got=%b exp=1", ready); end
    complete(5'd3);
    tick(2);
    total++; if (ext !== 1'b1) begin bad++; $display("FAIL single_repend got=%b exp=1", ext); end
    irq = '0;
  endtask

  task automatic test_priority();
    int exp_ids[4] = '{2, 5, 6, 0};
    logic [4:0] id;
    logic v;
    do_reset();
    wr(8'd2, 64'd5); wr(8'd5, 64'd5); wr(8'd6, 64'd4); wr(8'h40, 64'h64);
    irq = 8'h64;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      do_claim(id, v);
      total++; if (id !== 5'(exp_ids[k]) || v !== 1'b1) begin
        bad++; $display("FAIL prio_claim%0d got=%0d/%b exp=%0d/1", k, id, v, exp_ids[k]);
      end
    end
    irq = '0;
  endtask

  task automatic test_threshold();
    logic [4:0] id;
    logic v;
    logic [63:0] d;
    do_reset();
    wr(8'd4, 64'd3); wr(8'h41, 64'd3); wr(8'h40, 64'h10);
    irq[4] = 1'b1;
    tick(3);
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL thr_block got=%b exp=0", ext); end
    do_claim(id, v);
    total++; if (id !== 5'd0 || v !== 1'b1) begin bad++; $display("FAIL thr_claim0 got=%0d/%b exp=0/1", id, v); end
    wr(8'h41, 64'd2);
    tick();
    total++; if (ext !== 1'b1) begin bad++; $display("FAIL thr_pass got=%b exp=1", ext); end
    wr(8'h40, 64'h00);
    tick();
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL thr_disable got=%b exp=0", ext); end
    rd(8'h42, d);
    total++; if (d[4] !== 1'b1) begin bad++; $display("FAIL thr_pend_kept got=%b exp=1", d[4]); end
    irq = '0;
  endtask

  task automatic test_edge();
    logic [4:0] id;
    logic v;
    logic [63:0] d;
    do_reset();
    wr(8'h43, 64'h02); wr(8'd1, 64'd1); wr(8'h40, 64'h02);
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    tick(2);
    total++; if (ext !== 1'b1) begin bad++; $display("FAIL edge_req got=%b exp=1", ext); end
    do_claim(id, v);
    total++; if (id !== 5'd1) begin bad++; $display("FAIL edge_claim got=%0d exp=1", id); end
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    tick(2);
    rd(8'h42, d);
    total++; if (d[1] !== 1'b1) begin bad++; $display("FAIL edge_capture got=%b exp=1", d[1]); end
    total++; if (ext !== 1'b0) begin bad++; $display("FAIL edge_insvc_ext got=%b exp=0", ext); end
    complete(5'd1);
    tick();
    total++; if (ext !== 1'b1) begin bad++; $display("FAIL edge_after_cmp got=%b exp=1", ext); end
    irq[1] = 1'b1; claim = 1'b1;
    tick();
    irq[1] = 1'b0; claim = 1'b0;
    total++; if (cid !== 5'd1) begin bad++; $display("FAIL edge_coinc_cid got=%0d exp=1", cid); end
    tick(2);
    rd(8'h42, d);
    total++; if (d[1] !== 1'b1) begin bad++; $display("FAIL edge_coinc_pend got=%b exp=1", d[1]); end
    rd(8'h44, d);
    total++; if (d[1] !== 1'b1) begin bad++; $display("FAIL edge_coinc_svc got=%b exp=1", d[1]); end
  endtask

  task automatic test_abuse();
    int pulses = 0;
    logic [4:0] idv = '0;
    logic [63:0] d;
    do_reset();
    wr(8'd3, 64'd1); wr(8'h40, 64'h08);
    irq[3] = 1'b1;
    tick(3);
    claim = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) claim = 1'b0;
      tick();
      if (cvalid) begin pulses++; idv = cid; end
    end
    claim = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL abuse_pulses got=%0d exp=1", pulses); end
    total++; if (idv !== 5'd3) begin bad++; $display("FAIL abuse_id got=%0d exp=3", idv); end
    complete(5'd0);
    complete(5'd7);
    rd(8'h44, d);
    total++; if (d !== 64'h08) begin bad++; $display("FAIL abuse_svc got=%0h exp=8", d); end
    rd(8'h42, d);
    total++; if (d !== 64'h00) begin bad++; $display("FAIL abuse_pend got=%0h exp=0", d); end
    irq = '0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    do_reset();
    wr(8'd3, 64'd6); wr(8'h40, 64'h08);
    irq[3] = 1'b1;
    tick(3);
    rd(8'd3, d);
    total++; if (d !== 64'd6) begin bad++; $display("FAIL rmid_prio_rd got=%0h exp=6", d); end
    claim = 1'b1; tick(); claim = 1'b0;
    total++; if (cvalid !== 1'b1) begin bad++; $display("FAIL rmid_cvalid got=%b exp=1", cvalid); end
    rst = 1'b0;
    tick();
    irq = '0;
    total++; if ({ext, cvalid, ready} !== 3'b000) begin bad++; $display("FAIL rmid_outs got=%b exp=000", {ext, cvalid, ready}); end
    total++; if (cid !== 5'd0) begin bad++; $display("FAIL rmid_cid got=%0d exp=0", cid); end
    total++; if (rdata !== 64'd0) begin bad++; $display("FAIL rmid_rdata got=%0h exp=0", rdata); end
    rst = 1'b1;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b exp=1", ready); end
    rd(8'd3, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL rmid_prio got=%0h exp=0", d); end
    rd(8'h44, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL rmid_svc got=%0h exp=0", d); end
    rd(8'h42, d);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL rmid_pend got=%0h exp=0", d); end
  endtask

  task automatic test_random();
    int pr[8];
    int thr;
    int e;
    int j;
    int q[$];
    logic [7:0] en, iv, cand, svc;
    logic [4:0] id;
    logic v;
    logic [63:0] d;
    for (int r = 0; r < 12; r++) begin
      do_reset();
      thr = $urandom_range(0, 3);
      en = 8'($urandom) & 8'hFE;
      iv = 8'($urandom) & 8'hFE;
      pr[0] = 0;
      for (int i = 1; i < 8; i++) begin
        pr[i] = $urandom_range(0, 7);
        wr(8'(i), 64'(pr[i]));
      end
      wr(8'h40, 64'(en));
      wr(8'h41, 64'(thr));
      irq = iv;
      tick(3);
      cand = iv & en;
      svc = '0;
      e = model_pick(pr, cand, thr);
      total++; if (ext !== (e != 0)) begin bad++; $display("FAIL rnd%0d_ext got=%b exp=%b", r, ext, e != 0); end
      rd(8'h42, d);
      total++; if (d !== 64'(iv)) begin bad++; $display("FAIL rnd%0d_pend got=%0h exp=%0h", r, d, iv); end
      for (int k = 0; k < 8; k++) begin
        e = model_pick(pr, cand & ~svc, thr);
        do_claim(id, v);
        total++; if (id !== 5'(e)) begin bad++; $display("FAIL rnd%0d_claim%0d got=%0d exp=%0d", r, k, id, e); end
        if (e == 0) break;
        svc[e] = 1'b1;
      end
      rd(8'h44, d);
      total++; if (d !== 64'(svc)) begin bad++; $display("FAIL rnd%0d_svc got=%0h exp=%0h", r, d, svc); end
      if (svc != '0) begin
        q.delete();
        for (int i = 1; i < 8; i++) if (svc[i]) q.push_back(i);
        j = q[$urandom_range(0, q.size() - 1)];
        complete(5'(j));
        tick(2);
        do_claim(id, v);
        total++; if (id !== 5'(j)) begin bad++; $display("FAIL rnd%0d_reclaim got=%0d exp=%0d", r, id, j); end
      end
      irq = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_threshold();
    test_edge();
    test_abuse();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
